ecc_dec_pipe: RTL and testbench
===============================

# ecc_dec_pipe

Two-stage pipelined SEC-DED decoder for the extended Hamming codes produced by the encoder path: (8,4), (16,11) and (32,26), selected per word by `work_mod`. It takes a received codeword, computes the syndrome and overall parity, corrects any single-bit error, flags double errors, and returns the info bits. It sits on the receive side of the ECC datapath, behind the APB/AMBA register front-end. It uses a valid/ready handshake with backpressure.

## Interface
- `AMBA_WORD`, 32, width of `work_mod`.
- `MAX_CODEWORD_WIDTH`, 32, supported values are 8, 16 or 32; caps the largest enabled mode.
- `MAX_INFO_WIDTH`, 26, must be 4, 11 or 26 to match `MAX_CODEWORD_WIDTH`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  MAX_CODEWORD_WIDTH  received codeword, right-aligned, upper bits zero.
- `work_mod`  in  AMBA_WORD  mode: 0 = (8,4), 1 = (16,11), 2 = (32,26); sampled with `data_in`.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts the word this cycle.
- `data_out`  out  MAX_INFO_WIDTH  decoded info bits, right-aligned, upper bits zero.
- `num_of_errors`  out  2  0 = clean, 1 = corrected, 2 = uncorrectable.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.

## Operation
- The mode sets K/P/N: mode 0 is 4/4/8, mode 1 is 11/5/16, mode 2 is 26/6/32.
- Codeword layout: `{d[K-1:0], p[P-1:0]}`.
- `p[P-1]` is the overall even parity of all N bits.
- For i < P-1, `p[i]` = XOR of `d & M_i`.
- Masks for mode 0: M0=0xB, M1=0xD, M2=0xE.
- Masks for mode 1: M0=0x55B, M1=0x66D, M2=0x78E, M3=0x7F0.
- Masks for mode 2: M0=0x2AAAD5B, M1=0x333366D, M2=0x3C3C78E, M3=0x3FC07F0, M4=0x3FFF800.
- Stage 1 (registered):
  - syndrome `s[i] = p[i] ^ ^(d & M_i)` for i < P-1;
  - `ov = ^codeword[N-1:0]`;
  - the codeword and decoded mode are registered alongside.
- Stage 2 (registered): classify the word and form the output.
  - `ov=0, s=0`: pass data through, errors = 0.
  - `ov=1, s=0`: the error is in `p[P-1]`; data unchanged, errors = 1.
  - `ov=1, s!=0`: flip the single `d[j]` whose column `{M_{P-2}[j]..M_0[j]}` equals s, errors = 1. If s is one-hot, the error is in a check bit and data is unchanged.
  - `ov=1`, s matches no column: errors = 2, raw data passed through.
  - `ov=0, s!=0`: errors = 2, raw data passed through.
- Invalid mode (any value other than 0/1/2, or a mode exceeding `MAX_CODEWORD_WIDTH`): the word still flows through the pipe; `data_out` = 0, `num_of_errors` = 0.
- Codeword bits at N and above are ignored.

## Timing
- Reset values: `data_out`=0, `num_of_errors`=0, `out_valid`=0, internal stage valids=0. `in_ready`=1 once the pipe is empty.
- Stage 2 advances when `!s2_valid || out_ready`.
- Stage 1 advances when `!s1_valid || s2_adv`.
- `in_ready = s1_adv`. This is a combinational path from `out_ready` and is permitted.
- A transfer occurs on `in_valid && in_ready`. Output handshake is `out_valid && out_ready`.
- Latency: 2 cycles from input accept to `out_valid` with no stall. Throughput: 1 word per cycle.
- Outputs hold stable while `out_valid && !out_ready`.
- No loss or duplication under any stall pattern; at most 2 words are in flight.
- Reset asserted mid-stream clears both stages immediately; in-flight words are dropped.

## Configuration
- `ECC_DEC_STATS_EN` defined adds the following:
  - ports `stats_clr` (in, 1), `corr_cnt` (out, 16) and `uncorr_cnt` (out, 16);
  - each counter increments on an output handshake with errors = 1 or 2 respectively, and saturates at 0xFFFF;
  - `stats_clr` zeroes both counters synchronously and takes priority over an increment in the same cycle;
  - both counters reset to 0.
- `ECC_DEC_STATS_EN` undefined: these ports and the counters are absent.

## Test plan
- Mode 0, `data_in`=0xAA -> 2 cycles later `data_out`=0xA, `num_of_errors`=0.
- Single error:
  - mode 0, 0x8A (d[1] flipped) -> `data_out`=0xA, errors=1;
  - mode 2, zero codeword with bit 5 flipped (0x20) -> `data_out`=0, errors=1.
- Double error: mode 0, 0xA9 -> `data_out`=0xA (raw), errors=2. Mode 1, 0x8001 -> errors=2.
- Backpressure: stream 5 words back-to-back with `out_ready`=0 for cycles 2-5.
  - `in_ready` falls after 2 accepts;
  - all 5 results emerge in order, each exactly once.
- Invalid mode 3 with `data_in`=0xFFFF -> `data_out`=0, errors=0.
- Reset asserted with 2 words in flight -> `out_valid` falls immediately and no stale output appears after release.
- With `ECC_DEC_STATS_EN`: 3 corrected and 2 uncorrectable words -> `corr_cnt`=3, `uncorr_cnt`=2; `stats_clr` -> both 0.

Source files
------------

// File: rtl/ecc_dec_pipe.sv
// ecc_dec_pipe: two-stage SEC-DED decoder for (8,4)/(16,11)/(32,26) extended Hamming codes; ECC_DEC_STATS_EN adds error counters
module ecc_dec_pipe #(
    parameter int AMBA_WORD          = 32,
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [AMBA_WORD-1:0]          work_mod,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    num_of_errors,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef ECC_DEC_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [15:0]                   corr_cnt,
    output logic [15:0]                   uncorr_cnt
`endif
);

    localparam logic [25:0] MASK [4][5] = '{
        '{26'h000000B, 26'h000000D, 26'h000000E, 26'h0000000, 26'h0000000},
        '{26'h000055B, 26'h000066D, 26'h000078E, 26'h00007F0, 26'h0000000},
        '{26'h2AAAD5B, 26'h333366D, 26'h3C3C78E, 26'h3FC07F0, 26'h3FFF800},
        '{26'h0000000, 26'h0000000, 26'h0000000, 26'h0000000, 26'h0000000}};

    logic        s2_adv, s1_adv;
    logic        mode_ok, ov;
    logic [1:0]  mode_lo, mode;
    logic [31:0] cw;
    logic [25:0] dat;
    logic [4:0]  smask, syn;
    logic [25:0] flip, dec;
    logic        hit, onehot;
    logic [1:0]  err;
    logic        s1_valid_q, s1_valid_d, s1_ok_q, s1_ok_d, s1_ov_q, s1_ov_d;
    logic [1:0]  s1_mode_q, s1_mode_d;
    logic [4:0]  s1_syn_q, s1_syn_d;
    logic [25:0] s1_dat_q, s1_dat_d;
    logic        s2_valid_q, s2_valid_d;
    logic [25:0] dout_q, dout_d;
    logic [1:0]  err_q, err_d;

    always_comb begin
        mode_lo = work_mod[1:0];
        mode_ok = work_mod[AMBA_WORD-1:2] == '0 && (mode_lo == 2'd0 ||
                  (mode_lo == 2'd1 && MAX_CODEWORD_WIDTH >= 16) ||
                  (mode_lo == 2'd2 && MAX_CODEWORD_WIDTH >= 32));
        mode    = mode_ok ? mode_lo : 2'd0;
        cw      = 32'(data_in) & (mode == 2'd0 ? 32'h0000_00FF : mode == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF);
        dat     = mode == 2'd0 ? 26'(cw[7:4]) : mode == 2'd1 ? 26'(cw[15:5]) : cw[31:6];
        smask   = mode == 2'd0 ? 5'b00111 : mode == 2'd1 ? 5'b01111 : 5'b11111;
        ov      = ^cw;
        syn     = '0;
        for (int i = 0; i < 5; i++)
            syn[i] = smask[i] & (cw[i] ^ (^(dat & MASK[mode][i])));
    end

    // A data bit is corrected when its mask column equals the syndrome.
    always_comb begin
        flip = '0;
        for (int j = 0; j < 26; j++)
            flip[j] = s1_syn_q != 5'd0 && {MASK[s1_mode_q][4][j], MASK[s1_mode_q][3][j],
                      MASK[s1_mode_q][2][j], MASK[s1_mode_q][1][j], MASK[s1_mode_q][0][j]} == s1_syn_q;
        hit    = |flip;
        onehot = s1_syn_q != 5'd0 && (s1_syn_q & (s1_syn_q - 5'd1)) == 5'd0;
        err    = !s1_ok_q ? 2'd0 : s1_syn_q == 5'd0 ? {1'b0, s1_ov_q} :
                 (s1_ov_q && (hit || onehot)) ? 2'd1 : 2'd2;
        dec    = !s1_ok_q ? 26'd0 : s1_ov_q ? s1_dat_q ^ flip : s1_dat_q;
    end

    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_ok_d    = s1_adv && in_valid ? mode_ok : s1_ok_q;
        s1_ov_d    = s1_adv && in_valid ? ov : s1_ov_q;
        s1_mode_d  = s1_adv && in_valid ? mode : s1_mode_q;
        s1_syn_d   = s1_adv && in_valid ? syn : s1_syn_q;
        s1_dat_d   = s1_adv && in_valid ? dat : s1_dat_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        dout_d     = s2_adv && s1_valid_q ? dec : dout_q;
        err_d      = s2_adv && s1_valid_q ? err : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_ok_q    <= 1'b0;
            s1_ov_q    <= 1'b0;
            s1_mode_q  <= 2'd0;
            s1_syn_q   <= 5'd0;
            s1_dat_q   <= 26'd0;
            s2_valid_q <= 1'b0;
            dout_q     <= 26'd0;
            err_q      <= 2'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ok_q    <= s1_ok_d;
            s1_ov_q    <= s1_ov_d;
            s1_mode_q  <= s1_mode_d;
            s1_syn_q   <= s1_syn_d;
            s1_dat_q   <= s1_dat_d;
            s2_valid_q <= s2_valid_d;
            dout_q     <= dout_d;
            err_q      <= err_d;
        end
    end

    assign in_ready      = s1_adv;
    assign out_valid     = s2_valid_q;
    assign data_out      = dout_q[MAX_INFO_WIDTH-1:0];
    assign num_of_errors = err_q;

`ifdef ECC_DEC_STATS_EN
    logic        hs;
    logic [15:0] corr_q, corr_d, uncorr_q, uncorr_d;

    always_comb begin
        hs       = s2_valid_q && out_ready;
        corr_d   = stats_clr ? 16'd0 : (hs && err_q == 2'd1 && corr_q != 16'hFFFF) ? corr_q + 16'd1 : corr_q;
        uncorr_d = stats_clr ? 16'd0 : (hs && err_q == 2'd2 && uncorr_q != 16'hFFFF) ? uncorr_q + 16'd1 : uncorr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_q   <= 16'd0;
            uncorr_q <= 16'd0;
        end else begin
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
        end
    end

    assign corr_cnt   = corr_q;
    assign uncorr_cnt = uncorr_q;
`endif

endmodule

// File: tb/tb_ecc_dec_pipe.sv
// tb_ecc_dec_pipe: vector table, hand sequences and random traffic against a brute-force SEC-DED model
module tb_ecc_dec_pipe;

    typedef struct { logic [25:0] d; logic [1:0] e; } res_t;
    typedef struct { logic [31:0] m; logic [31:0] cw; logic [25:0] d; logic [1:0] e; } vec_t;

    localparam logic [25:0] MT [3][5] = '{
        '{26'h000000B, 26'h000000D, 26'h000000E, 26'h0, 26'h0},
        '{26'h000055B, 26'h000066D, 26'h000078E, 26'h00007F0, 26'h0},
        '{26'h2AAAD5B, 26'h333366D, 26'h3C3C78E, 26'h3FC07F0, 26'h3FFF800}};
    localparam int KT [3] = '{4, 11, 26};
    localparam int PT [3] = '{4, 5, 6};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic [31:0] work_mod = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] data_out;
    logic [1:0]  num_of_errors;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef ECC_DEC_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] corr_cnt, uncorr_cnt;
`endif

    int   n_chk = 0, n_err = 0, n_out = 0;
    logic acc;
    res_t sb[$];
    res_t nil = '{26'd0, 2'd0};
    vec_t tbl[14];

    always #5 clk = ~clk;

    ecc_dec_pipe dut (
        .clk(clk), .rst(rst), .data_in(data_in), .work_mod(work_mod),
        .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
        .num_of_errors(num_of_errors), .out_valid(out_valid), .out_ready(out_ready)
`ifdef ECC_DEC_STATS_EN
        , .stats_clr(stats_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
`endif
    );

    function automatic logic [31:0] enc(int m, logic [25:0] d);
        logic [31:0] c;
        logic [25:0] dm;
        dm = d & ((26'd1 << KT[m]) - 26'd1);
        c  = 32'(dm) << PT[m];
        for (int i = 0; i < PT[m] - 1; i++) c[i] = ^(dm & MT[m][i]);
        c[PT[m]-1] = ^c;
        return c;
    endfunction

    // Reference: a word is clean if it re-encodes to itself, correctable if exactly one bit flip makes it so.
    function automatic res_t refm(logic [31:0] md, logic [31:0] raw);
        res_t r;
        int m, n;
        logic [31:0] c, t;
        logic [25:0] d;
        r = '{26'd0, 2'd0};
        if (md > 32'd2) return r;
        m = int'(md);
        n = 8 << m;
        c = n == 32 ? raw : raw & ((32'd1 << n) - 32'd1);
        d = 26'(c >> PT[m]);
        r.d = d;
        if (enc(m, d) == c) return r;
        for (int b = 0; b < n; b++) begin
            t = c ^ (32'd1 << b);
            if (enc(m, 26'(t >> PT[m])) == t) begin
                r.d = 26'(t >> PT[m]);
                r.e = 2'd1;
                return r;
            end
        end
        r.e = 2'd2;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] din, input logic [31:0] md, input logic ordy, input res_t exp);
        res_t r;
        @(negedge clk);
        in_valid = v; data_in = din; work_mod = md; out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL spurious_output: got data %0h errs %0d expected none", data_out, num_of_errors);
            end else begin
                r = sb.pop_front();
                chk("data_out", 32'(data_out), 32'(r.d));
                chk("num_of_errors", 32'(num_of_errors), 32'(r.e));
            end
        end
        if (acc) sb.push_back(exp);
    endtask

    task automatic send(input logic [31:0] din, input logic [31:0] md);
        cyc(1'b1, din, md, 1'b1, refm(md, din));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, nil);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int idx, base, m, k;
        logic [31:0] c;
        tbl[0]  = '{32'd0, 32'h000000AA, 26'hA,   2'd0};
        tbl[1]  = '{32'd0, 32'h0000008A, 26'hA,   2'd1};
        tbl[2]  = '{32'd2, 32'h00000020, 26'h0,   2'd1};
        tbl[3]  = '{32'd0, 32'h000000A9, 26'hA,   2'd2};
        tbl[4]  = '{32'd1, 32'h00008001, 26'h400, 2'd2};
        tbl[5]  = '{32'd3, 32'h0000FFFF, 26'h0,   2'd0};
        tbl[6]  = '{32'd0, 32'h00000000, 26'h0,   2'd0};
        tbl[7]  = '{32'd0, 32'h000001AA, 26'hA,   2'd0};
        tbl[8]  = '{32'd0, 32'h000000AB, 26'hA,   2'd1};
        tbl[9]  = '{32'd1, 32'h00000020, 26'h0,   2'd1};
        tbl[10] = '{32'd7, 32'hFFFFFFFF, 26'h0,   2'd0};
        tbl[11] = '{32'd2, 32'h80000000, 26'h0,   2'd1};
        tbl[12] = '{32'd0, 32'h000000FF, 26'hF,   2'd0};
        tbl[13] = '{32'd0, 32'h00000003, 26'h0,   2'd2};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_errors", 32'(num_of_errors), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) cyc(1'b1, tbl[i].cw, tbl[i].m, 1'b1, '{tbl[i].d, tbl[i].e});
        drain();

        cyc(1'b1, 32'hAA, 32'd0, 1'b1, '{26'hA, 2'd0});
        cyc(1'b0, 32'd0, 32'd0, 1'b1, nil);
        chk("latency_1", 32'(out_valid), 32'd0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, nil);
        chk("latency_2", 32'(out_valid), 32'd1);
        drain();

        begin
            logic [31:0] w [5] = '{32'hAA, 32'h8A, 32'hA9, 32'hFF, 32'h03};
            idx = 0;
            base = n_out;
            for (int c2 = 1; c2 <= 5; c2++) begin
                cyc(1'b1, w[idx], 32'd0, c2 == 1, refm(32'd0, w[idx]));
                if (acc) idx++;
                if (c2 >= 3) chk("bp_in_ready", 32'(in_ready), 32'd0);
            end
            chk("bp_accepts", 32'(idx), 32'd2);
            for (int b = 0; b < 20 && idx < 5; b++) begin
                cyc(1'b1, w[idx], 32'd0, 1'b1, refm(32'd0, w[idx]));
                if (acc) idx++;
            end
            drain();
            chk("bp_outputs", 32'(n_out - base), 32'd5);
        end

        cyc(1'b1, 32'h8A, 32'd0, 1'b1, refm(32'd0, 32'h8A));
        cyc(1'b1, 32'hA9, 32'd0, 1'b1, refm(32'd0, 32'hA9));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 32'd0, 32'd0, 1'b1, nil);
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            m = $urandom_range(0, 9) == 0 ? int'($urandom_range(3, 8)) : int'($urandom_range(0, 2));
            k = $urandom_range(0, 4);
            c = m < 3 ? enc(m, 26'($urandom)) : $urandom;
            if (m < 3 && k == 4) c = $urandom;
            else if (m < 3) for (int f = 0; f < k; f++) c ^= 32'd1 << $urandom_range(0, (8 << m) - 1);
            if (m < 2 && $urandom_range(0, 3) == 0) c |= $urandom << (8 << m);
            cyc($urandom_range(0, 3) != 0, c, 32'(m), $urandom_range(0, 2) != 0, refm(32'(m), c));
        end
        drain();

`ifdef ECC_DEC_STATS_EN
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        chk("stats_clr_corr", 32'(corr_cnt), 32'd0);
        chk("stats_clr_uncorr", 32'(uncorr_cnt), 32'd0);
        repeat (3) send(32'h8A, 32'd0);
        repeat (2) send(32'hA9, 32'd0);
        drain();
        chk("corr_cnt", 32'(corr_cnt), 32'd3);
        chk("uncorr_cnt", 32'(uncorr_cnt), 32'd2);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        chk("corr_cnt_clr", 32'(corr_cnt), 32'd0);
        chk("uncorr_cnt_clr", 32'(uncorr_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
